// File: rtl/spkr_envelope_pkg.sv
// Shared types for the ADSR envelope stage: phase encoding and rate width.
package spkr_envelope_pkg;

  localparam int RATE_BITS = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_t;

endpackage

// File: rtl/spkr_envelope_step.sv
// Envelope step timer: a unit prescaler followed by a step counter that fires
// once every (rate+1) units. Both counters restart whenever the phase changes.
module env_step_timer
  import spkr_envelope_pkg::*;
#(
  parameter int STEP_UNIT = 256,
  parameter int UNIT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic [RATE_BITS-1:0] i_rate,
  output logic                 o_step
);

  localparam logic [UNIT_BITS-1:0] UNIT_LAST = UNIT_BITS'(STEP_UNIT - 1);

  logic [UNIT_BITS-1:0] r_unit_cnt;
  logic [RATE_BITS-1:0] r_step_cnt;
  logic                 w_unit_tick;

  assign w_unit_tick = (r_unit_cnt == UNIT_LAST);
  // Rate is read live; >= lets a lowered rate fire on the very next unit tick.
  assign o_step      = w_unit_tick && (r_step_cnt >= i_rate);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_unit_cnt <= '0;
      r_step_cnt <= '0;
    end else if (i_clear) begin
      r_unit_cnt <= '0;
      r_step_cnt <= '0;
    end else begin
      r_unit_cnt <= w_unit_tick ? '0 : r_unit_cnt + 1'b1;
      if (o_step)
        r_step_cnt <= '0;
      else if (w_unit_tick)
        r_step_cnt <= r_step_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spkr_envelope.sv
// ADSR envelope for the SN76477 speaker tone: gate synchroniser, phase FSM,
// envelope level register and PWM gating of the tone into the AMP2 input.
module spkr_envelope
  import spkr_envelope_pkg::*;
#(
  parameter int ENV_BITS  = 8,
  parameter int STEP_UNIT = 256,
  parameter int UNIT_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tone_in,
  input  logic                 gate,
  input  logic [RATE_BITS-1:0] attack_rate,
  input  logic [RATE_BITS-1:0] decay_rate,
  input  logic [ENV_BITS-1:0]  sustain_level,
  input  logic [RATE_BITS-1:0] release_rate,
  output logic                 spkr_out,
  output logic [ENV_BITS-1:0]  env_level,
  output logic                 busy
);

  localparam logic [ENV_BITS-1:0] ENV_MAX = '1;

  logic                 r_gate_s1;
  logic                 r_gate_s2;
  logic                 r_gate_prev;
  logic [1:0]           r_sync_fill;
  logic                 r_gate_armed;
  logic                 w_gate_rise;
  logic                 w_gate_fall;

  env_state_t           r_state;
  env_state_t           w_state_next;
  logic [ENV_BITS-1:0]  r_env;
  logic [ENV_BITS-1:0]  w_env_next;
  logic [RATE_BITS-1:0] w_rate;
  logic                 w_step;
  logic                 w_clear;

  logic [ENV_BITS-1:0]  r_pwm_cnt;
  logic                 r_spkr;
  logic                 r_busy;

  // A gate already high when reset lifts must not count as a rise: rises are
  // only accepted once the synchroniser has shown a genuine low level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gate_s1    <= 1'b0;
      r_gate_s2    <= 1'b0;
      r_gate_prev  <= 1'b0;
      r_sync_fill  <= 2'b00;
      r_gate_armed <= 1'b0;
    end else begin
      r_gate_s1    <= gate;
      r_gate_s2    <= r_gate_s1;
      r_gate_prev  <= r_gate_s2;
      r_sync_fill  <= {r_sync_fill[0], 1'b1};
      r_gate_armed <= r_gate_armed | (r_sync_fill[1] & ~r_gate_s2);
    end
  end

  assign w_gate_rise = r_gate_s2 & ~r_gate_prev & r_gate_armed;
  assign w_gate_fall = ~r_gate_s2 & r_gate_prev;

  always_comb begin
    w_rate = '0;
    case (r_state)
      ST_ATTACK:  w_rate = attack_rate;
      ST_DECAY:   w_rate = decay_rate;
      ST_RELEASE: w_rate = release_rate;
      default:    w_rate = '0;
    endcase
  end

  env_step_timer #(
    .STEP_UNIT (STEP_UNIT),
    .UNIT_BITS (UNIT_BITS)
  ) u_step_timer (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_rate  (w_rate),
    .o_step  (w_step)
  );

  always_comb begin
    w_state_next = r_state;
    w_env_next   = r_env;
    case (r_state)
      ST_IDLE: begin
        w_env_next = '0;
        if (w_gate_rise)
          w_state_next = ST_ATTACK;
      end
      ST_ATTACK: begin
        if (w_gate_fall)
          w_state_next = ST_RELEASE;
        else if (r_env == ENV_MAX)
          w_state_next = ST_DECAY;
        else if (w_step)
          w_env_next = r_env + 1'b1;
      end
      ST_DECAY: begin
        if (w_gate_fall)
          w_state_next = ST_RELEASE;
        else if (r_env <= sustain_level) begin
          w_env_next   = sustain_level;
          w_state_next = ST_SUSTAIN;
        end else if (w_step)
          w_env_next = r_env - 1'b1;
      end
      ST_SUSTAIN: begin
        if (w_gate_fall)
          w_state_next = ST_RELEASE;
        else
          w_env_next = sustain_level;
      end
      ST_RELEASE: begin
        if (w_gate_rise)
          w_state_next = ST_ATTACK;
        else if (r_env == '0)
          w_state_next = ST_IDLE;
        else if (w_step)
          w_env_next = r_env - 1'b1;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_env_next   = '0;
      end
    endcase
  end

  assign w_clear = (w_state_next != r_state);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_env     <= '0;
      r_busy    <= 1'b0;
      r_pwm_cnt <= '0;
      r_spkr    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_env     <= w_env_next;
      r_busy    <= (w_state_next != ST_IDLE);
      r_pwm_cnt <= r_pwm_cnt + 1'b1;
      r_spkr    <= tone_in & (r_env > r_pwm_cnt);
    end
  end

  assign spkr_out  = r_spkr;
  assign env_level = r_env;
  assign busy      = r_busy;

endmodule

// File: tb/tb_spkr_envelope.sv
// Bench for spkr_envelope: envelope trajectories predicted from phase entry
// times and step periods, PWM duty from window counts and counter phase.
module tb_spkr_envelope;

  localparam int STEP_UNIT = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tone_in = 1'b0;
  logic       gate = 1'b0;
  logic [3:0] attack_rate = '0;
  logic [3:0] decay_rate = '0;
  logic [3:0] release_rate = '0;
  logic [7:0] sustain_level = '0;
  logic       spkr_out;
  logic [7:0] env_level;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  spkr_envelope #(
    .ENV_BITS  (8),
    .STEP_UNIT (STEP_UNIT),
    .UNIT_BITS (8)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tone_in       (tone_in),
    .gate          (gate),
    .attack_rate   (attack_rate),
    .decay_rate    (decay_rate),
    .sustain_level (sustain_level),
    .release_rate  (release_rate),
    .spkr_out      (spkr_out),
    .env_level     (env_level),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  function automatic int period(input int rate);
    return (rate + 1) * STEP_UNIT;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    gate = 1'b0;
    tone_in = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_env(input logic [7:0] v, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (env_level === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (env_level !== 8'd0 || busy !== 1'b0 || spkr_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: env=%0d busy=%0b spkr=%0b expected 0/0/0", env_level, busy, spkr_out);
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (env_level !== 8'd0 || busy !== 1'b0 || spkr_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: env=%0d busy=%0b spkr=%0b expected 0/0/0", env_level, busy, spkr_out);
    end
  endtask

  task automatic test_adsr();
    int ar, dr, rr, s, s2, pa, pd, pr, ex, eb;
    for (int it = 0; it < 3; it++) begin
      ar = (it == 0) ? 0 : int'($urandom_range(0, 2));
      dr = (it == 0) ? 1 : int'($urandom_range(0, 2));
      s  = (it == 0) ? 128 : ((it == 2) ? 255 : int'($urandom_range(0, 254)));
      s2 = (it == 0) ? 100 : int'($urandom_range(0, 80));
      rr = int'($urandom_range(0, 2));
      pa = period(ar);
      pd = period(dr);
      pr = period(rr);
      do_reset();
      attack_rate = 4'(ar);
      decay_rate = 4'(dr);
      release_rate = 4'(rr);
      sustain_level = 8'(s);
      gate = 1'b1;
      for (int i = 0; i < 2; i++) begin
        tick();
        n_checks++;
        if (busy !== 1'b0 || env_level !== 8'd0) begin
          n_fail++;
          $display("FAIL adsr_sync it=%0d: busy=%0b env=%0d expected 0/0", it, busy, env_level);
        end
      end
      tick();
      n_checks++;
      if (busy !== 1'b1 || env_level !== 8'd0) begin
        n_fail++;
        $display("FAIL adsr_start it=%0d: busy=%0b env=%0d expected 1/0", it, busy, env_level);
      end
      for (int n = 1; n <= 255 * pa; n++) begin
        tick();
        ex = n / pa;
        n_checks++;
        if (env_level !== 8'(ex)) begin
          n_fail++;
          $display("FAIL adsr_attack it=%0d n=%0d: env=%0d expected %0d", it, n, env_level, ex);
        end
      end
      for (int m = 0; m <= (255 - s) * pd + 1; m++) begin
        tick();
        ex = 255 - m / pd;
        if (ex < s) ex = s;
        n_checks++;
        if (env_level !== 8'(ex) || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL adsr_decay it=%0d m=%0d: env=%0d busy=%0b expected %0d/1", it, m, env_level, busy, ex);
        end
      end
      sustain_level = 8'(s2);
      tick();
      n_checks++;
      if (env_level !== 8'(s2) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL adsr_sustain_follow it=%0d: env=%0d busy=%0b expected %0d/1", it, env_level, busy, s2);
      end
      gate = 1'b0;
      repeat (2) tick();
      for (int m = 0; m <= s2 * pr + 1; m++) begin
        tick();
        ex = s2 - m / pr;
        if (ex < 0) ex = 0;
        eb = (m <= s2 * pr) ? 1 : 0;
        n_checks++;
        if (env_level !== 8'(ex) || busy !== 1'(eb)) begin
          n_fail++;
          $display("FAIL adsr_release it=%0d m=%0d: env=%0d busy=%0b expected %0d/%0d", it, m, env_level, busy, ex, eb);
        end
      end
    end
  endtask

  task automatic test_pwm();
    bit   ok;
    int   cnt, k1, lv2, t, ex;
    int   lv_tab[4];
    logic prev;
    lv_tab = '{64, int'($urandom_range(1, 254)), 255, 0};
    do_reset();
    attack_rate = 4'd0;
    decay_rate = 4'd0;
    sustain_level = 8'd64;
    gate = 1'b1;
    wait_env(8'd255, 1200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pwm_reach_max: env=%0d expected 255", env_level); end
    wait_env(8'd64, 1200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL pwm_reach_sustain: env=%0d expected 64", env_level); end
    repeat (2) tick();
    tone_in = 1'b1;
    for (int j = 0; j < 4; j++) begin
      sustain_level = 8'(lv_tab[j]);
      repeat (2) tick();
      cnt = 0;
      repeat (256) begin tick(); cnt += int'(spkr_out); end
      n_checks++;
      if (cnt !== lv_tab[j]) begin
        n_fail++;
        $display("FAIL pwm_duty level=%0d: high cycles=%0d expected %0d", lv_tab[j], cnt, lv_tab[j]);
      end
    end
    tone_in = 1'b0;
    sustain_level = 8'd200;
    repeat (2) tick();
    cnt = 0;
    repeat (256) begin tick(); cnt += int'(spkr_out); end
    n_checks++;
    if (cnt !== 0) begin n_fail++; $display("FAIL pwm_tone_off: high cycles=%0d expected 0", cnt); end
    tone_in = 1'b1;
    sustain_level = 8'd64;
    repeat (2) tick();
    prev = 1'b1;
    k1 = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (spkr_out === 1'b1 && prev === 1'b0) begin k1 = cyc; break; end
      prev = spkr_out;
    end
    n_checks++;
    if (k1 < 0) begin n_fail++; $display("FAIL pwm_phase: no rising edge found, expected one"); end
    if (k1 >= 0) begin
      lv2 = int'($urandom_range(1, 254));
      sustain_level = 8'(lv2);
      repeat (2) tick();
      for (int i = 0; i < 300; i++) begin
        t = int'($urandom_range(0, 1));
        tone_in = 1'(t);
        tick();
        ex = (t == 1 && lv2 > ((cyc - k1) % 256)) ? 1 : 0;
        n_checks++;
        if (spkr_out !== 1'(ex)) begin
          n_fail++;
          $display("FAIL pwm_random_tone i=%0d level=%0d: spkr=%0b expected %0d", i, lv2, spkr_out, ex);
        end
      end
    end
    tone_in = 1'b0;
  endtask

  task automatic test_release_retrigger();
    bit ok;
    int rr, pr, ex, eb;
    do_reset();
    attack_rate = 4'd0;
    decay_rate = 4'd0;
    release_rate = 4'd0;
    sustain_level = 8'd128;
    gate = 1'b1;
    wait_env(8'd255, 1200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_reach_max: env=%0d expected 255", env_level); end
    wait_env(8'd128, 1200, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL rr_reach_sustain: env=%0d expected 128", env_level); end
    repeat (2) tick();
    gate = 1'b0;
    repeat (3) tick();
    for (int m = 1; m <= 312; m++) begin
      tick();
      ex = 128 - m / 4;
      n_checks++;
      if (env_level !== 8'(ex)) begin
        n_fail++;
        $display("FAIL rr_release m=%0d: env=%0d expected %0d", m, env_level, ex);
      end
    end
    gate = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++;
      if (env_level !== 8'd50 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_retrigger_hold i=%0d: env=%0d busy=%0b expected 50/1", i, env_level, busy);
      end
    end
    for (int n = 1; n <= 4; n++) begin
      tick();
      ex = 50 + n / 4;
      n_checks++;
      if (env_level !== 8'(ex)) begin
        n_fail++;
        $display("FAIL rr_reattack n=%0d: env=%0d expected %0d", n, env_level, ex);
      end
    end
    rr = int'($urandom_range(0, 3));
    pr = period(rr);
    release_rate = 4'(rr);
    gate = 1'b0;
    repeat (3) tick();
    for (int m = 0; m <= 51 * pr + 1; m++) begin
      if (m > 0) tick();
      ex = 51 - m / pr;
      if (ex < 0) ex = 0;
      eb = (m <= 51 * pr) ? 1 : 0;
      n_checks++;
      if (env_level !== 8'(ex) || busy !== 1'(eb)) begin
        n_fail++;
        $display("FAIL rr_final_release m=%0d: env=%0d busy=%0b expected %0d/%0d", m, env_level, busy, ex, eb);
      end
    end
  endtask

  task automatic test_priority();
    bit ok;
    int ex;
    do_reset();
    attack_rate = 4'd0;
    release_rate = 4'd15;
    sustain_level = 8'd0;
    gate = 1'b1;
    wait_env(8'd254, 1100, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL prio_reach: env=%0d expected 254", env_level); end
    tick();
    gate = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (env_level !== 8'd254 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL prio_fall_vs_step: env=%0d busy=%0b expected 254/1", env_level, busy);
    end
    for (int m = 1; m <= 64; m++) begin
      tick();
      ex = 254 - m / 64;
      n_checks++;
      if (env_level !== 8'(ex)) begin
        n_fail++;
        $display("FAIL prio_release m=%0d: env=%0d expected %0d", m, env_level, ex);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    do_reset();
    attack_rate = 4'd0;
    sustain_level = 8'd0;
    tone_in = 1'b1;
    gate = 1'b1;
    wait_env(8'd100, 600, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL areset_reach: env=%0d expected 100", env_level); end
    #3 reset = 1'b0;
    #1;
    n_checks++;
    if (env_level !== 8'd0 || busy !== 1'b0 || spkr_out !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: env=%0d busy=%0b spkr=%0b expected 0/0/0", env_level, busy, spkr_out);
    end
    repeat (2) tick();
    #3 reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++;
      if (env_level !== 8'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL areset_no_restart i=%0d: env=%0d busy=%0b expected 0/0", i, env_level, busy);
      end
    end
    gate = 1'b0;
    repeat (3) tick();
    gate = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL areset_fresh_sync: busy=%0b expected 0", busy); end
    tick();
    n_checks++;
    if (busy !== 1'b1 || env_level !== 8'd0) begin
      n_fail++;
      $display("FAIL areset_fresh_rise: busy=%0b env=%0d expected 1/0", busy, env_level);
    end
    gate = 1'b0;
    tone_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_adsr();
    test_pwm();
    test_release_retrigger();
    test_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
